// File: rtl/vga_timing_gen_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
//   Shared raster constants for the 640x480@60 display path.
//   Default sync/porch widths, derived totals and visible-window bounds are
//   expressed in raw counter values (hCount=0 is the first hSync pixel), so
//   vga_bitchange can place sprites directly in these coordinates.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

   // Counter width; both axis totals must fit in it.
   localparam int unsigned CNT_W     = 10;
   localparam int unsigned MAX_TOTAL = 1 << CNT_W;

   typedef logic [CNT_W-1:0] count_t;   // hCount / vCount
   typedef logic [CNT_W:0]   bound_t;   // bounds may reach MAX_TOTAL itself
   typedef logic [3:0]       div_t;     // pixel divider, CLK_DIV up to 16

   // 100 MHz board clock -> 25 MHz pixel clock.
   localparam int unsigned DEF_CLK_DIV   = 4;

   localparam int unsigned DEF_H_SYNC    = 96;
   localparam int unsigned DEF_H_BACK    = 48;
   localparam int unsigned DEF_H_VISIBLE = 640;
   localparam int unsigned DEF_H_FRONT   = 16;

   localparam int unsigned DEF_V_SYNC    = 2;
   localparam int unsigned DEF_V_BACK    = 33;
   localparam int unsigned DEF_V_VISIBLE = 480;
   localparam int unsigned DEF_V_FRONT   = 10;

   localparam int unsigned DEF_H_TOTAL =
      DEF_H_SYNC + DEF_H_BACK + DEF_H_VISIBLE + DEF_H_FRONT;   // 800
   localparam int unsigned DEF_V_TOTAL =
      DEF_V_SYNC + DEF_V_BACK + DEF_V_VISIBLE + DEF_V_FRONT;   // 525

   // Visible window: start inclusive, end exclusive.
   localparam int unsigned DEF_H_VIS_START = DEF_H_SYNC + DEF_H_BACK;          // 144
   localparam int unsigned DEF_H_VIS_END   = DEF_H_VIS_START + DEF_H_VISIBLE;  // 784
   localparam int unsigned DEF_V_VIS_START = DEF_V_SYNC + DEF_V_BACK;          // 35
   localparam int unsigned DEF_V_VIS_END   = DEF_V_VIS_START + DEF_V_VISIBLE;  // 515

endpackage

// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
//   Raster timing bundle from vga_timing_gen to its consumers.
//   hCount/vCount : raw counters (0 = start of sync)
//   hSync/vSync   : active-low sync pulses
//   bright        : pixel lies in the visible window
//   pix_en        : one-clk strobe per pixel period
//   line_start    : one-clk pulse when hCount becomes 0
//   frame_start   : one-clk pulse when (hCount,vCount) becomes (0,0)
//   modport master: timing generator; modport slave: renderer / game logic.
// ---------------------------------------------------------------------------
interface vga_timing_gen_if;

   vga_timing_pkg::count_t hCount;
   vga_timing_pkg::count_t vCount;
   logic                   hSync;
   logic                   vSync;
   logic                   bright;
   logic                   pix_en;
   logic                   line_start;
   logic                   frame_start;

   modport master (
      output hCount, vCount, hSync, vSync, bright, pix_en, line_start, frame_start
   );

   modport slave (
      input  hCount, vCount, hSync, vSync, bright, pix_en, line_start, frame_start
   );

endinterface

// File: rtl/vga_axis_counter.sv
// ---------------------------------------------------------------------------
// vga_axis_counter
//   One raster axis: counts 0..TOTAL-1 in the order sync, back porch,
//   visible, front porch, advancing only when adv_i is high.
//   Ports:
//     clk_i, rst_n_i : clock, asynchronous active-low reset
//     adv_i          : advance the count this cycle
//     count_o        : current count (registered)
//     last_o         : count_o == TOTAL-1 (next advance wraps to 0)
//     sync_n_o       : active-low sync decode (registered)
//     active_o       : visible-window decode (registered)
//   Decodes are registered from the next-count value so they change on the
//   same edge as count_o, with no skew against it.
// ---------------------------------------------------------------------------
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int unsigned SYNC    = DEF_H_SYNC,
   parameter int unsigned BACK    = DEF_H_BACK,
   parameter int unsigned VISIBLE = DEF_H_VISIBLE,
   parameter int unsigned FRONT   = DEF_H_FRONT
) (
   input  logic   clk_i,
   input  logic   rst_n_i,
   input  logic   adv_i,
   output count_t count_o,
   output logic   last_o,
   output logic   sync_n_o,
   output logic   active_o
);

   localparam int unsigned TOTAL = SYNC + BACK + VISIBLE + FRONT;

   if (TOTAL > MAX_TOTAL || TOTAL < 2) begin : g_bad_total
      $error("vga_axis_counter: axis total %0d outside 2..%0d", TOTAL, MAX_TOTAL);
   end

   localparam count_t LAST      = count_t'(TOTAL - 1);
   localparam bound_t SYNC_END  = bound_t'(SYNC);
   localparam bound_t VIS_START = bound_t'(SYNC + BACK);
   localparam bound_t VIS_END   = bound_t'(SYNC + BACK + VISIBLE);

   count_t count_q, count_d;
   logic   sync_n_q, sync_n_d;
   logic   active_q, active_d;
   logic   last;

   assign last = (count_q == LAST);

   always_comb begin
      count_d = count_q;
      if (adv_i) begin
         count_d = last ? '0 : count_q + count_t'(1);
      end
      sync_n_d = ({1'b0, count_d} >= SYNC_END);
      active_d = ({1'b0, count_d} >= VIS_START) && ({1'b0, count_d} < VIS_END);
   end

   // Reset puts the axis at 0 with sync asserted (0 lies inside the pulse).
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         count_q  <= '0;
         sync_n_q <= 1'b0;
         active_q <= 1'b0;
      end else begin
         count_q  <= count_d;
         sync_n_q <= sync_n_d;
         active_q <= active_d;
      end
   end

   assign count_o  = count_q;
   assign last_o   = last;
   assign sync_n_o = sync_n_q;
   assign active_o = active_q;

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Raster timing generator for the VGA output path.
//   Divides clk by CLK_DIV into a pixel strobe, runs the horizontal and
//   vertical axis counters on it, and emits line/frame pulses for game logic.
//   Ports:
//     clk   : system clock (100 MHz)
//     reset : asynchronous active-low reset (0 = in reset)
//     vga   : vga_timing_gen_if master (hCount, vCount, hSync, vSync,
//             bright, pix_en, line_start, frame_start)
//   Every output comes from a flop (bright is the AND of two flops); there is
//   no combinational path from any input.
// ---------------------------------------------------------------------------
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
   parameter int unsigned H_SYNC    = DEF_H_SYNC,
   parameter int unsigned H_BACK    = DEF_H_BACK,
   parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
   parameter int unsigned H_FRONT   = DEF_H_FRONT,
   parameter int unsigned V_SYNC    = DEF_V_SYNC,
   parameter int unsigned V_BACK    = DEF_V_BACK,
   parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
   parameter int unsigned V_FRONT   = DEF_V_FRONT
) (
   input  logic             clk,
   input  logic             reset,
   vga_timing_gen_if.master vga
);

   localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
   localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;

   if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
      $error("vga_timing_gen: CLK_DIV %0d outside 1..16", CLK_DIV);
   end
   if (H_TOTAL > MAX_TOTAL) begin : g_bad_h
      $error("vga_timing_gen: H_TOTAL %0d exceeds %0d", H_TOTAL, MAX_TOTAL);
   end
   if (V_TOTAL > MAX_TOTAL) begin : g_bad_v
      $error("vga_timing_gen: V_TOTAL %0d exceeds %0d", V_TOTAL, MAX_TOTAL);
   end

   localparam div_t DIV_LAST = div_t'(CLK_DIV - 1);

   div_t   div_q, div_d;
   logic   pix_en_q, pix_en_d;
   logic   line_start_q, line_start_d;
   logic   frame_start_q, frame_start_d;

   count_t h_count, v_count;
   logic   h_last, v_last;
   logic   h_sync_n, v_sync_n;
   logic   h_active, v_active;
   logic   v_adv;

   // Vertical axis steps on the pixel that wraps the horizontal axis.
   assign v_adv = pix_en_q & h_last;

   vga_axis_counter #(
      .SYNC    (H_SYNC),
      .BACK    (H_BACK),
      .VISIBLE (H_VISIBLE),
      .FRONT   (H_FRONT)
   ) u_h_axis (
      .clk_i    (clk),
      .rst_n_i  (reset),
      .adv_i    (pix_en_q),
      .count_o  (h_count),
      .last_o   (h_last),
      .sync_n_o (h_sync_n),
      .active_o (h_active)
   );

   vga_axis_counter #(
      .SYNC    (V_SYNC),
      .BACK    (V_BACK),
      .VISIBLE (V_VISIBLE),
      .FRONT   (V_FRONT)
   ) u_v_axis (
      .clk_i    (clk),
      .rst_n_i  (reset),
      .adv_i    (v_adv),
      .count_o  (v_count),
      .last_o   (v_last),
      .sync_n_o (v_sync_n),
      .active_o (v_active)
   );

   // pix_en is registered from the next divider value, so it is high exactly
   // while div_q == CLK_DIV-1. With CLK_DIV=1 div_d is always 0 and pix_en
   // stays high from the first edge after reset release.
   always_comb begin
      div_d         = (div_q == DIV_LAST) ? '0 : div_q + div_t'(1);
      pix_en_d      = (div_d == DIV_LAST);
      line_start_d  = v_adv;
      frame_start_d = v_adv & v_last;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_q         <= '0;
         pix_en_q      <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         div_q         <= div_d;
         pix_en_q      <= pix_en_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign vga.hCount      = h_count;
   assign vga.vCount      = v_count;
   assign vga.hSync       = h_sync_n;
   assign vga.vSync       = v_sync_n;
   assign vga.bright      = h_active & v_active;
   assign vga.pix_en      = pix_en_q;
   assign vga.line_start  = line_start_q;
   assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//   Directed bench for vga_timing_gen. Three instances share one clock:
//     u_def  : default 640x480 timing, CLK_DIV=4 (reset, pixel strobe, lines)
//     u_sml  : reduced raster 12x8 (H 3/2/5/2, V 2/1/3/2), CLK_DIV=2
//              -> frame = 12*8*2 = 192 clk, visible h 5..9, v 3..5, 15 pixels
//     u_fast : same reduced raster with CLK_DIV=1 -> frame = 96 clk
//   Outputs are sampled on the falling edge; each falling edge after a
//   release on a falling edge lies in clk cycle (n+1) counted from release.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic rst_d, rst_s, rst_f;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;
   int unsigned n_fail  = 0;

   always #5 clk = ~clk;

   vga_timing_gen_if vd ();
   vga_timing_gen_if vs ();
   vga_timing_gen_if vf ();

   vga_timing_gen #(.CLK_DIV(4)) u_def (
      .clk   (clk),
      .reset (rst_d),
      .vga   (vd)
   );

   vga_timing_gen #(
      .CLK_DIV(2), .H_SYNC(3), .H_BACK(2), .H_VISIBLE(5), .H_FRONT(2),
      .V_SYNC(2), .V_BACK(1), .V_VISIBLE(3), .V_FRONT(2)
   ) u_sml (
      .clk   (clk),
      .reset (rst_s),
      .vga   (vs)
   );

   vga_timing_gen #(
      .CLK_DIV(1), .H_SYNC(3), .H_BACK(2), .H_VISIBLE(5), .H_FRONT(2),
      .V_SYNC(2), .V_BACK(1), .V_VISIBLE(3), .V_FRONT(2)
   ) u_fast (
      .clk   (clk),
      .reset (rst_f),
      .vga   (vf)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Bounded wait until the reduced-raster instance sits at (h,v).
   task automatic wait_pos_s(input int h, input int v, output int n);
      n = 0;
      while (!(vs.hCount == h && vs.vCount == v) && n < 400) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      int n, t;
      int max_h, max_v, hs_low, hs_bad, vs_low, vs_bad, br_cnt, br_bad, ls_cnt, fs_cnt, no_pix;
      logic model;

      rst_d = 1'b0;
      rst_s = 1'b0;
      rst_f = 1'b0;

      // ---------------- reset state (default instance) ----------------
      repeat (10) @(negedge clk);
      check("rst_hCount",      32'(vd.hCount), 0);
      check("rst_vCount",      32'(vd.vCount), 0);
      check("rst_hSync",       32'(vd.hSync), 0);
      check("rst_vSync",       32'(vd.vSync), 0);
      check("rst_bright",      32'(vd.bright), 0);
      check("rst_pix_en",      32'(vd.pix_en), 0);
      check("rst_line_start",  32'(vd.line_start), 0);
      check("rst_frame_start", 32'(vd.frame_start), 0);

      // ---------------- pixel strobe ----------------
      // Cycles after release carry div=0,1,2,3: pix_en in cycle 4 = 3rd sample.
      rst_d = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!vd.pix_en && n < 20);
      check("first_pix_en_wait", n, 3);
      check("hCount_at_first_pix_en", 32'(vd.hCount), 0);
      t = n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            check("hCount_after_pix_en", 32'(vd.hCount), 1);
            check("pix_en_one_clk", 32'(vd.pix_en), 0);
         end
      end while (!vd.pix_en && n < 20);
      check("pix_en_period", n, 4);
      t += n;

      // ---------------- line timing ----------------
      // 800th pix_en in cycle 4+799*4=3200, line_start in cycle 3201.
      while (!vd.line_start && t < 4000) begin @(negedge clk); t++; end
      check("first_line_start_wait", t, 3200);
      check("line_start_hCount", 32'(vd.hCount), 0);
      check("line_start_vCount", 32'(vd.vCount), 1);

      t = 0; max_h = 0; hs_low = 0; hs_bad = 0; br_cnt = 0; fs_cnt = 0;
      do begin
         @(negedge clk);
         t++;
         if (int'(vd.hCount) > max_h) max_h = int'(vd.hCount);
         if (!vd.hSync) hs_low++;
         if ((vd.hCount < 96) == vd.hSync) hs_bad++;
         if (vd.bright) br_cnt++;
         if (vd.frame_start) fs_cnt++;
      end while (!vd.line_start && t < 4000);
      check("line_period", t, 3200);
      check("hSync_low_clks", hs_low, 96 * 4);
      check("hSync_vs_hCount", hs_bad, 0);
      check("hCount_max", max_h, 799);
      check("bright_in_vsync_lines", br_cnt, 0);
      check("no_early_frame_start", fs_cnt, 0);
      check("second_line_vCount", 32'(vd.vCount), 2);

      // ---------------- reduced raster, CLK_DIV=2 ----------------
      check("sml_rst_hSync",  32'(vs.hSync), 0);
      check("sml_rst_vSync",  32'(vs.vSync), 0);
      check("sml_rst_pix_en", 32'(vs.pix_en), 0);
      @(negedge clk);
      rst_s = 1'b1;
      // 96th pix_en in cycle 2+95*2=192, frame_start in cycle 193.
      t = 0; ls_cnt = 0;
      do begin
         @(negedge clk);
         t++;
         if (vs.line_start) ls_cnt++;
      end while (!vs.frame_start && t < 400);
      check("sml_first_frame_wait", t, 192);
      check("sml_lines_per_frame", ls_cnt, 8);
      check("sml_fs_with_ls", 32'(vs.line_start), 1);
      check("sml_fs_hCount", 32'(vs.hCount), 0);
      check("sml_fs_vCount", 32'(vs.vCount), 0);

      t = 0; max_h = 0; max_v = 0; hs_bad = 0; vs_low = 0; vs_bad = 0; br_cnt = 0; br_bad = 0;
      do begin
         @(negedge clk);
         t++;
         if (int'(vs.hCount) > max_h) max_h = int'(vs.hCount);
         if (int'(vs.vCount) > max_v) max_v = int'(vs.vCount);
         if ((vs.hCount < 3) == vs.hSync) hs_bad++;
         if (!vs.vSync) vs_low++;
         if ((vs.vCount < 2) == vs.vSync) vs_bad++;
         model = (vs.hCount >= 5 && vs.hCount < 10 && vs.vCount >= 3 && vs.vCount < 6);
         if (model !== vs.bright) br_bad++;
         if (vs.bright && vs.pix_en) br_cnt++;
      end while (!vs.frame_start && t < 400);
      check("sml_frame_period", t, 192);
      check("sml_hCount_max", max_h, 11);
      check("sml_vCount_max", max_v, 7);
      check("sml_hSync_vs_hCount", hs_bad, 0);
      check("sml_vSync_low_clks", vs_low, 2 * 12 * 2);
      check("sml_vSync_vs_vCount", vs_bad, 0);
      check("sml_bright_window", br_bad, 0);
      check("sml_bright_pixels", br_cnt, 15);

      // Window corners, in raster order.
      wait_pos_s(5, 2, n);  check("reach_5_2", 32'(n < 400), 1);  check("bright_5_2", 32'(vs.bright), 0);
      wait_pos_s(4, 3, n);  check("reach_4_3", 32'(n < 400), 1);  check("bright_4_3", 32'(vs.bright), 0);
      wait_pos_s(5, 3, n);  check("reach_5_3", 32'(n < 400), 1);  check("bright_5_3", 32'(vs.bright), 1);
      wait_pos_s(10, 3, n); check("reach_10_3", 32'(n < 400), 1); check("bright_10_3", 32'(vs.bright), 0);
      wait_pos_s(9, 5, n);  check("reach_9_5", 32'(n < 400), 1);  check("bright_9_5", 32'(vs.bright), 1);
      wait_pos_s(5, 6, n);  check("reach_5_6", 32'(n < 400), 1);  check("bright_5_6", 32'(vs.bright), 0);

      // ---------------- mid-frame reset ----------------
      wait_pos_s(6, 4, n);
      check("reach_6_4", 32'(n < 400), 1);
      check("pre_rst_bright", 32'(vs.bright), 1);
      #1 rst_s = 1'b0;
      #1;
      check("midrst_hCount", 32'(vs.hCount), 0);
      check("midrst_vCount", 32'(vs.vCount), 0);
      check("midrst_hSync",  32'(vs.hSync), 0);
      check("midrst_vSync",  32'(vs.vSync), 0);
      check("midrst_bright", 32'(vs.bright), 0);
      @(negedge clk);
      rst_s = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!vs.frame_start && t < 400);
      check("midrst_frame_wait", t, 192);
      check("midrst_fs_hCount", 32'(vs.hCount), 0);
      check("midrst_fs_vCount", 32'(vs.vCount), 0);

      // ---------------- reduced raster, CLK_DIV=1 ----------------
      // pix_en first high in cycle 2; 96th pix_en in cycle 97, frame_start cycle 98.
      @(negedge clk);
      rst_f = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!vf.frame_start && t < 400);
      check("fast_first_frame_wait", t, 97);
      t = 0; no_pix = 0; br_cnt = 0;
      do begin
         @(negedge clk);
         t++;
         if (!vf.pix_en) no_pix++;
         if (vf.bright && vf.pix_en) br_cnt++;
      end while (!vf.frame_start && t < 400);
      check("fast_frame_period", t, 96);
      check("fast_pix_en_gaps", no_pix, 0);
      check("fast_bright_pixels", br_cnt, 15);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Produces the raster timing consumed by the pixel renderer: hCount, vCount, bright, hSync, vSync.
- Sits between the board clock and vga_bitchange, and drives the display connector sync pins.
- Also emits a pixel strobe and per-line/per-frame pulses so game logic (physics, pipes, score) can tick once per frame.
- Fixed counting order per axis: sync, back porch, visible, front porch. hCount=0 is the start of hSync.

Parameters:
- CLK_DIV, 4, clk cycles per pixel (100 MHz -> 25 MHz); legal 1..16
- H_SYNC, 96, hSync pulse width in pixels
- H_BACK, 48, horizontal back porch in pixels
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch in pixels
- V_SYNC, 2, vSync pulse width in lines
- V_BACK, 33, vertical back porch in lines
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch in lines

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- hCount  out  10  horizontal pixel count, 0..H_TOTAL-1
- vCount  out  10  vertical line count, 0..V_TOTAL-1
- hSync  out  1  horizontal sync, active-low
- vSync  out  1  vertical sync, active-low
- bright  out  1  high when the current pixel is in the visible window
- pix_en  out  1  one-clk strobe, once per pixel period
- line_start  out  1  one-clk pulse when hCount becomes 0
- frame_start  out  1  one-clk pulse when (hCount,vCount) becomes (0,0)

Behaviour:
- Derived totals: H_TOTAL = H_SYNC+H_BACK+H_VISIBLE+H_FRONT (800); V_TOTAL likewise (525). Both must be <= 1024; otherwise elaboration fails via a static check.
- Reset (reset=0, async): divider=0 and every output is 0: hCount, vCount, hSync, vSync, bright, pix_en, line_start, frame_start. This state is consistent because (0,0) lies inside both sync pulses.
- Divider: counts 0..CLK_DIV-1 and wraps. pix_en is registered and high for exactly the clk cycle in which div==CLK_DIV-1.
  - CLK_DIV=1: pix_en is high on every cycle after reset release.
- Counter update: on each clk with pix_en=1:
  - hCount increments; at H_TOTAL-1 it wraps to 0.
  - On that wrap, vCount increments; at V_TOTAL-1 it wraps to 0.
  - hCount and vCount hold on all other cycles.
- Decodes: hSync, vSync and bright are registered and updated in the same cycle as the counters, from the next-count values. They are therefore always consistent with the visible hCount/vCount, with zero skew.
  - hSync=0 iff hCount < H_SYNC.
  - vSync=0 iff vCount < V_SYNC.
  - bright=1 iff H_SYNC+H_BACK <= hCount < H_SYNC+H_BACK+H_VISIBLE (144..783) and V_SYNC+V_BACK <= vCount < V_SYNC+V_BACK+V_VISIBLE (35..514).
- line_start: high for 1 clk, in the cycle following the pix_en that wrapped hCount to 0.
- frame_start: high for 1 clk, in the cycle following the pix_en that wrapped both counters to 0. It coincides with a line_start pulse.
- The reset state does not count as a wrap: the first frame_start occurs one full frame after reset release.
- Reset mid-frame: all outputs return to 0 immediately (asynchronously) and counting restarts from (0,0) on release.
- Output latency: all outputs come directly from flops; there is no combinational path from any input.

Decomposition:
- Package vga_timing_pkg holds:
  - the default 640x480@60 porch/sync constants;
  - derived H_TOTAL/V_TOTAL and visible start/end constants, shared with vga_bitchange (for example, sprite positions are expressed in these raw counts).
- Sub-module vga_axis_counter (params SYNC, BACK, VISIBLE, FRONT), instantiated once for h and once for v:
  - inputs: advance enable;
  - outputs: count, wrap flag, sync and active decodes.
  - The top level ANDs the two active decodes into bright.

Test Plan:
- Reset: hold reset=0 for 10 clk -> all outputs 0. Release -> first pix_en on clk 4 and every 4 clk thereafter; hCount reaches 1 after the first pix_en.
- Line timing: run 1 line -> hSync=0 exactly for hCount 0..95; line_start period = 800*4 = 3200 clk; hCount never exceeds 799.
- Frame timing: run 2 frames -> vSync=0 only for vCount 0..1; frame_start period = 800*525*4 = 1,680,000 clk; no frame_start before the first wrap.
- Visible window: count (bright & pix_en) over one frame -> 307,200. bright=0 at (143,35), (784,35), (144,34) and (144,515); bright=1 at (144,35) and (783,514).
- Reset mid-frame: assert reset at (400,300) -> outputs 0 in the same cycle without waiting for a clk edge; after release, counting restarts from (0,0) and the next frame_start comes 1,680,000 clk later.
- Parameter sweep with CLK_DIV=1 -> pix_en constantly 1 after release; frame period 420,000 clk; bright count still 307,200.
